// File: rtl/syscall_console.sv
// ---------------------------------------------------------------------------------------------
// syscall_console
//
// Host-side service endpoint for the single-cycle MIPS core's syscall convention. Accepts a
// request (v0 = service number, a0 = argument) and performs one of:
//   - print-integer : a0 as signed decimal ASCII, leading zeros suppressed, '-' first if negative
//   - print-char    : a0[7:0] as one byte
//   - exit          : latch a0 into o_exit_code, raise o_halted and stop for good
// Output bytes leave over a valid/ready byte channel. o_busy stalls the core while a print runs.
//
// Optional feature macro: SYSCALL_NEWLINE_EN
//   defined   -> every print-integer ends with 0x0A (state StNl)
//   undefined -> no newline, StNl not built
//
// Ports:
//   i_clock          clock, rising edge
//   i_reset_n        asynchronous active-low reset
//   i_syscall_valid  core executes syscall this cycle
//   i_v0 [31:0]      service number
//   i_a0 [31:0]      argument (signed)
//   o_busy           service in progress
//   o_tx_data [7:0]  output byte
//   o_tx_valid       o_tx_data valid
//   i_tx_ready       sink accepts byte
//   o_halted         exit executed (sticky)
//   o_exit_code      a0 latched at exit
//   o_unsupported    unknown service number seen (sticky)
// ---------------------------------------------------------------------------------------------
module syscall_console #(
    parameter int unsigned SVC_PRINT_INT  = 1,
    parameter int unsigned SVC_EXIT       = 10,
    parameter int unsigned SVC_PRINT_CHAR = 11
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_syscall_valid,
    input  logic [31:0] i_v0,
    input  logic [31:0] i_a0,
    output logic        o_busy,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_halted,
    output logic [31:0] o_exit_code,
    output logic        o_unsupported
);

    localparam logic [31:0] LP_INT  = 32'(SVC_PRINT_INT);
    localparam logic [31:0] LP_EXIT = 32'(SVC_EXIT);
    localparam logic [31:0] LP_CHAR = 32'(SVC_PRINT_CHAR);

    // Index of the last power (10^0); also used by print-char so EMIT sees "no powers left".
    localparam logic [3:0] LP_LAST_IDX = 4'd9;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StSign = 3'd1,
        StConv = 3'd2,
        StEmit = 3'd3,
        StHalt = 3'd4
`ifdef SYSCALL_NEWLINE_EN
        ,
        StNl   = 3'd5
`endif
    } state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_rem, w_rem_d;          // magnitude still to be printed
    logic [3:0]  r_idx, w_idx_d;          // 0 -> 10^9 ... 9 -> 10^0
    logic [3:0]  r_digit, w_digit_d;      // subtractions done for the current power
    logic        r_started, w_started_d;  // a nonzero digit has been emitted
    logic [7:0]  r_tx_data, w_tx_data_d;
    logic        r_halted, w_halted_d;
    logic [31:0] r_exit_code, w_exit_code_d;
    logic        r_unsupported, w_unsupported_d;
`ifdef SYSCALL_NEWLINE_EN
    logic        r_is_int, w_is_int_d;    // newline only follows print-integer
`endif

    logic        w_accept;
    logic        w_xfer;
    logic [31:0] w_pow;
    logic [31:0] w_mag;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1000000000;
            4'd1:    pow10 = 32'd100000000;
            4'd2:    pow10 = 32'd10000000;
            4'd3:    pow10 = 32'd1000000;
            4'd4:    pow10 = 32'd100000;
            4'd5:    pow10 = 32'd10000;
            4'd6:    pow10 = 32'd1000;
            4'd7:    pow10 = 32'd100;
            4'd8:    pow10 = 32'd10;
            default: pow10 = 32'd1;
        endcase
    endfunction

    // Outputs decode straight from the state so an asynchronous reset drops them at once.
    assign o_busy        = (r_state != StIdle) && (r_state != StHalt);
`ifdef SYSCALL_NEWLINE_EN
    assign o_tx_valid    = (r_state == StSign) || (r_state == StEmit) || (r_state == StNl);
`else
    assign o_tx_valid    = (r_state == StSign) || (r_state == StEmit);
`endif
    assign o_tx_data     = r_tx_data;
    assign o_halted      = r_halted;
    assign o_exit_code   = r_exit_code;
    assign o_unsupported = r_unsupported;

    assign w_accept = i_syscall_valid && !o_busy && !r_halted;
    assign w_xfer   = o_tx_valid && i_tx_ready;
    assign w_pow    = pow10(r_idx);
    // Two's-complement negate of -2^31 gives 0x80000000, which is the correct unsigned magnitude.
    assign w_mag    = i_a0[31] ? (~i_a0 + 32'd1) : i_a0;

    always_comb begin
        w_state_d       = r_state;
        w_rem_d         = r_rem;
        w_idx_d         = r_idx;
        w_digit_d       = r_digit;
        w_started_d     = r_started;
        w_tx_data_d     = r_tx_data;
        w_halted_d      = r_halted;
        w_exit_code_d   = r_exit_code;
        w_unsupported_d = r_unsupported;
`ifdef SYSCALL_NEWLINE_EN
        w_is_int_d      = r_is_int;
`endif

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (i_v0 == LP_CHAR) begin
                        w_tx_data_d = i_a0[7:0];
                        w_idx_d     = LP_LAST_IDX;
                        w_state_d   = StEmit;
`ifdef SYSCALL_NEWLINE_EN
                        w_is_int_d  = 1'b0;
`endif
                    end else if (i_v0 == LP_INT) begin
                        w_rem_d     = w_mag;
                        w_idx_d     = 4'd0;
                        w_digit_d   = 4'd0;
                        w_started_d = 1'b0;
`ifdef SYSCALL_NEWLINE_EN
                        w_is_int_d  = 1'b1;
`endif
                        if (i_a0[31]) begin
                            w_tx_data_d = 8'h2D;
                            w_state_d   = StSign;
                        end else begin
                            w_state_d   = StConv;
                        end
                    end else if (i_v0 == LP_EXIT) begin
                        w_halted_d    = 1'b1;
                        w_exit_code_d = i_a0;
                        w_state_d     = StHalt;
                    end else begin
                        w_unsupported_d = 1'b1;
                    end
                end
            end

            StSign: begin
                if (w_xfer) begin
                    w_state_d = StConv;
                end
            end

            // One subtraction per cycle; the first cycle with remainder < power decides the digit.
            StConv: begin
                if (r_rem >= w_pow) begin
                    w_rem_d   = r_rem - w_pow;
                    w_digit_d = r_digit + 4'd1;
                end else if ((r_digit != 4'd0) || r_started || (r_idx == LP_LAST_IDX)) begin
                    w_tx_data_d = 8'h30 + {4'h0, r_digit};
                    w_started_d = 1'b1;
                    w_state_d   = StEmit;
                end else begin
                    w_idx_d   = r_idx + 4'd1;
                    w_digit_d = 4'd0;
                end
            end

            StEmit: begin
                if (w_xfer) begin
                    if (r_idx != LP_LAST_IDX) begin
                        w_idx_d   = r_idx + 4'd1;
                        w_digit_d = 4'd0;
                        w_state_d = StConv;
                    end else begin
`ifdef SYSCALL_NEWLINE_EN
                        if (r_is_int) begin
                            w_tx_data_d = 8'h0A;
                            w_state_d   = StNl;
                        end else begin
                            w_state_d   = StIdle;
                        end
`else
                        w_state_d = StIdle;
`endif
                    end
                end
            end

`ifdef SYSCALL_NEWLINE_EN
            StNl: begin
                if (w_xfer) begin
                    w_state_d = StIdle;
                end
            end
`endif

            StHalt: begin
                w_state_d = StHalt;
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_rem         <= 32'd0;
            r_idx         <= 4'd0;
            r_digit       <= 4'd0;
            r_started     <= 1'b0;
            r_tx_data     <= 8'h00;
            r_halted      <= 1'b0;
            r_exit_code   <= 32'd0;
            r_unsupported <= 1'b0;
`ifdef SYSCALL_NEWLINE_EN
            r_is_int      <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_d;
            r_rem         <= w_rem_d;
            r_idx         <= w_idx_d;
            r_digit       <= w_digit_d;
            r_started     <= w_started_d;
            r_tx_data     <= w_tx_data_d;
            r_halted      <= w_halted_d;
            r_exit_code   <= w_exit_code_d;
            r_unsupported <= w_unsupported_d;
`ifdef SYSCALL_NEWLINE_EN
            r_is_int      <= w_is_int_d;
`endif
        end
    end

endmodule

// File: tb/tb_syscall_console.sv
// ---------------------------------------------------------------------------------------------
// tb_syscall_console
//
// Directed bench for syscall_console. Stimulus pushes the bytes each request must produce into a
// scoreboard queue; an independent monitor pops and compares every byte that transfers.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
// ---------------------------------------------------------------------------------------------
module tb_syscall_console;

    logic        clk;
    logic        rst_n;
    logic        syscall_valid;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;
    logic [31:0] exit_code;
    logic        unsupported;

    int n_cmp = 0;
    int n_err = 0;
    int n_rx  = 0;
    logic [7:0] exp_q[$];

    syscall_console dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_syscall_valid (syscall_valid),
        .i_v0            (v0),
        .i_a0            (a0),
        .o_busy          (busy),
        .o_tx_data       (tx_data),
        .o_tx_valid      (tx_valid),
        .i_tx_ready      (tx_ready),
        .o_halted        (halted),
        .o_exit_code     (exit_code),
        .o_unsupported   (unsupported)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: a byte transfers at the next rising edge when valid & ready now.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && tx_valid && tx_ready) begin
                n_rx++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got 0x%02h, expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_err++;
                        $display("FAIL byte: got 0x%02h, expected 0x%02h", tx_data, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; returns 1 unit after the accepting edge with v0/a0 scrambled.
    task automatic req(input logic [31:0] sv, input logic [31:0] arg);
        tick();
        syscall_valid = 1'b1;
        v0 = sv;
        a0 = arg;
        tick();
        syscall_valid = 1'b0;
        v0 = $urandom;
        a0 = $urandom;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_nl();
`ifdef SYSCALL_NEWLINE_EN
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (busy) begin
            n_err++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
        end
        tick();
        check({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic print_int(input string name, input logic [31:0] val, input string s);
        push_str(s);
        push_nl();
        req(32'd1, val);
        wait_idle(name, 150);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        syscall_valid = 1'b0;
        v0 = 32'd0;
        a0 = 32'd0;
        tx_ready = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_halted", halted, 0);
        check("rst_exit_code", exit_code, 0);
        check("rst_unsupported", unsupported, 0);
        rst_n = 1'b1;
        tick();

        print_int("int_1234", 32'd1234, "1234");
        print_int("int_min", 32'h8000_0000, "-2147483648");
        print_int("int_zero", 32'd0, "0");
        print_int("int_neg7", 32'hFFFF_FFF9, "-7");
        print_int("int_1000", 32'd1000, "1000");

        // Print-char with ready high: busy exactly one cycle.
        exp_q.push_back(8'h5A);
        req(32'd11, 32'h0000_005A);
        check("pc_busy_1st", busy, 1);
        check("pc_valid_1st", tx_valid, 1);
        tick();
        check("pc_busy_2nd", busy, 0);
        check("pc_queue_left", exp_q.size(), 0);

        // Print-char with the sink stalled for 5 cycles.
        tx_ready = 1'b0;
        exp_q.push_back(8'h41);
        req(32'd11, 32'h0000_0141);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            check("stall_valid", tx_valid, 1);
            check("stall_data", tx_data, 32'h41);
            check("stall_busy", busy, 1);
        end
        tx_ready = 1'b1;
        wait_idle("stall_char", 10);

        // Unknown service.
        req(32'd5, 32'd3);
        check("unsup_flag", unsupported, 1);
        check("unsup_busy", busy, 0);
        check("unsup_valid", tx_valid, 0);
        tick();
        print_int("int_9", 32'd9, "9");
        check("unsup_sticky", unsupported, 1);

        // Exit, then an ignored print-char.
        req(32'd10, 32'd7);
        check("exit_halted", halted, 1);
        check("exit_code", exit_code, 7);
        check("exit_busy", busy, 0);
        check("exit_valid", tx_valid, 0);
        req(32'd11, 32'h0000_0042);
        for (int i = 0; i < 4; i++) begin
            check("halt_busy", busy, 0);
            check("halt_valid", tx_valid, 0);
            tick();
        end
        check("halt_sticky", halted, 1);

        rst_n = 1'b0;
        #1;
        check("rst2_halted", halted, 0);
        check("rst2_exit_code", exit_code, 0);
        check("rst2_unsupported", unsupported, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a print-int after two bytes.
        exp_q.push_back(8'h39);
        exp_q.push_back(8'h38);
        n_rx = 0;
        req(32'd1, 32'd987654321);
        for (int k = 0; k < 100 && n_rx < 2; k++) tick();
        check("mid_two_bytes", n_rx, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", tx_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("mid_no_more_bytes", n_rx, 2);
        check("mid_queue_left", exp_q.size(), 0);

        print_int("int_42", 32'd42, "42");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/syscall_console.md
# syscall_console

Host-side service endpoint for the single-cycle MIPS core's syscall convention. It consumes the core's syscall request (`v0` service number, `a0` argument) and performs the selected service:

- print a signed integer as decimal ASCII;
- print a character;
- exit, which latches the exit code and halts.

Output bytes stream over a valid/ready byte channel. `busy` stalls the core while a service is in progress.

## Interface
Parameters:
- `SVC_PRINT_INT`, default 1: `v0` value selecting print-integer.
- `SVC_EXIT`, default 10: `v0` value selecting exit.
- `SVC_PRINT_CHAR`, default 11: `v0` value selecting print-character.

Ports:
- `clock`  in  1  : single clock; all state changes on the rising edge.
- `reset`  in  1  : asynchronous, active-low reset.
- `syscall_valid`  in  1  : core is executing `syscall` this cycle.
- `v0`  in  32  : service number.
- `a0`  in  32  : argument, signed two's complement.
- `busy`  out  1  : service in progress; core holds PC and request.
- `tx_data`  out  8  : output byte.
- `tx_valid`  out  1  : `tx_data` is valid.
- `tx_ready`  in  1  : sink accepts the byte.
- `halted`  out  1  : exit executed; sticky.
- `exit_code`  out  32  : `a0` latched at exit.
- `unsupported`  out  1  : sticky; set when an unknown `v0` is accepted.

## Operation
- **Accept.** A request is accepted at an edge where `syscall_valid & !busy & !halted`. At that edge `v0` and `a0` are captured. Outside that condition, requests are ignored.
- **FSM states.** IDLE, SIGN, CONV, EMIT, NL, HALT.
- **IDLE, on accept:**
  - `SVC_PRINT_CHAR`: go to EMIT with byte `a0[7:0]`; this is the last byte.
  - `SVC_PRINT_INT`: if `a0 < 0`, go to SIGN and emit 0x2D. Otherwise go to CONV.
  - `SVC_EXIT`: go to HALT. `halted=1`, `exit_code=a0`.
  - Any other value: set `unsupported` and stay in IDLE. `busy` is not asserted.
- **Magnitude.** Magnitude = |`a0`| as 32-bit unsigned. -2^31 yields 2147483648; no overflow.
- **CONV.** Walk the powers 10^9 down to 10^0.
  - For each power p, subtract p from the remainder once per cycle while remainder >= p, counting into digit d (0..9).
  - Emit `0x30+d` via EMIT if `d!=0`, or a nonzero digit was already emitted, or p = 10^0. This gives leading-zero suppression, and value 0 prints as "0".
  - Otherwise advance to the next power without emitting.
- **EMIT.** Hold `tx_data` with `tx_valid=1` until the handshake completes. Then:
  - return to CONV if powers remain;
  - else go to NL (macro enabled, print-int only);
  - else go to IDLE.
- **HALT.** Absorbing state until reset. No bytes are emitted.

## Timing
- **Reset.** Asserting `reset` low immediately clears all outputs and state, even mid-service:
  - `busy=0`, `tx_valid=0`, `tx_data=0x00`, `halted=0`, `exit_code=0`, `unsupported=0`;
  - FSM returns to IDLE.
- **`busy`.**
  - Rises after the accepting edge for print-char and print-int.
  - Falls after the edge at which the final byte completes its handshake.
  - Exit never raises `busy`.
- **Handshake.**
  - A byte transfers at an edge with `tx_valid & tx_ready`.
  - While `tx_valid & !tx_ready`, `tx_data` is stable and `tx_valid` stays high.
  - `tx_valid` never drops without a transfer, except on reset.
- **Print-char latency.** `tx_valid` rises after the accepting edge. With `tx_ready=1`, `busy` is high for exactly 1 cycle.
- **Print-int latency.**
  - Each power costs (d+1) CONV cycles, plus one EMIT cycle if emitted.
  - Worst case with `tx_ready=1` is at most 120 cycles.
  - The sign byte is the first output.
- **Ignored inputs.** `syscall_valid` while `busy` or `halted` is ignored. `v0`/`a0` changes after acceptance have no effect.
- **Exit timing.** `halted` and `exit_code` update at the accepting edge.

## Configuration
- `SYSCALL_NEWLINE_EN` defined: every print-int appends 0x0A (via state NL) after its last digit. `busy` falls only after the newline transfers. Print-char is unaffected.
- Undefined: no newline is emitted and the NL state is not built.

## Test plan
- print-int, `a0=1234`, `tx_ready=1` -> bytes 0x31,0x32,0x33,0x34 in order, then `busy=0`.
  - With `SYSCALL_NEWLINE_EN`: the same bytes followed by 0x0A.
- print-int, `a0=-2147483648` -> 11 bytes "-2147483648", first 0x2D. Also `a0=0` -> single 0x30.
- print-char, `a0=0x00000141`, `tx_ready` low 5 cycles then high -> `tx_data=0x41` and `tx_valid=1` held stable all 5 cycles, one transfer, then `busy=0`.
- exit, `a0=7` -> `halted=1`, `exit_code=7`, no `tx_valid`. A following print-char request produces no bytes and `busy` stays 0.
- `v0=5` -> `unsupported=1`, `busy` stays 0, no bytes. A subsequent print-int `a0=9` emits 0x39.
- Reset low during print-int `a0=987654321` after 2 bytes -> `tx_valid`/`busy` drop immediately, no further bytes. After release, a fresh print-int `a0=42` emits 0x34,0x32.
